// File: rtl/taxi_eth_phy_10g_pkg.sv
// taxi_eth_phy_10g_pkg: shared TX gearbox FSM state type and default sequence length
package taxi_eth_phy_10g_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SYNC, ST_RUN} gbx_state_t;
  localparam int GBX_SEQ_LEN = 33;
endpackage

// File: rtl/taxi_eth_phy_10g_gbx_seq.sv
// taxi_eth_phy_10g_gbx_seq: gearbox sequence counter (clk, rst, clear, enable -> count, last = next count is SEQ_LEN-1)
module taxi_eth_phy_10g_gbx_seq import taxi_eth_phy_10g_pkg::*; #(
  parameter int SEQ_LEN = GBX_SEQ_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  output logic [5:0] count,
  output logic       last
);
  logic wrap;
  always_comb begin
    wrap = count == 6'(SEQ_LEN - 1);
    last = enable && !clear && count == 6'(SEQ_LEN - 2);
  end
  always_ff @(posedge clk)
    count <= (rst || clear) ? '0 : enable ? (wrap ? '0 : count + 6'd1) : count;
endmodule

// File: rtl/taxi_eth_phy_10g_tx_gbx_ctrl.sv
// taxi_eth_phy_10g_tx_gbx_ctrl: 10G TX gearbox control (req_sync/req_stall in; registered valid/hdr/sync/ready/half/status out)
module taxi_eth_phy_10g_tx_gbx_ctrl import taxi_eth_phy_10g_pkg::*; #(
  parameter int DATA_W       = 64,
  parameter bit INT_SEQ_EN   = 1'b0,
  parameter int SEQ_LEN      = GBX_SEQ_LEN,
  parameter bit SYNC_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_gbx_req_sync,
  input  logic       tx_gbx_req_stall,
  output logic       encoded_tx_data_valid,
  output logic       encoded_tx_hdr_valid,
  output logic       tx_gbx_sync,
  output logic       enc_tx_ready,
  output logic       enc_tx_half,
  output logic [5:0] stat_seq_count,
  output logic       stat_stall_err,
  output logic       stat_locked
);
  localparam bit W32 = DATA_W == 32;
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_w
    $fatal(1, "DATA_W must be 32 or 64");
  end
  if (SEQ_LEN < 2 || SEQ_LEN > 64) begin : g_bad_len
    $fatal(1, "SEQ_LEN must be in 2..64");
  end
  gbx_state_t state;
  logic phase, seq_last, go, run_n, stall_c, adv, ph_n;
  taxi_eth_phy_10g_gbx_seq #(.SEQ_LEN(SEQ_LEN)) u_seq (
    .clk(clk),
    .rst(rst),
    .clear(tx_gbx_req_sync || state != ST_RUN),
    .enable(state == ST_RUN),
    .count(stat_seq_count),
    .last(seq_last)
  );
  always_comb begin
    go      = state == ST_IDLE ? !SYNC_WAIT_EN : tx_gbx_req_sync;
    run_n   = state == ST_RUN || go;
    stall_c = state == ST_RUN && !go && (INT_SEQ_EN ? seq_last : tx_gbx_req_stall);
    adv     = run_n && !stall_c;
    ph_n    = go ? 1'b0 : phase;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= ST_IDLE;
      phase                 <= 1'b0;
      encoded_tx_data_valid <= 1'b0;
      encoded_tx_hdr_valid  <= 1'b0;
      tx_gbx_sync           <= 1'b0;
      enc_tx_ready          <= 1'b0;
      enc_tx_half           <= 1'b0;
      stat_stall_err        <= 1'b0;
      stat_locked           <= 1'b0;
    end else begin
      state                 <= run_n ? ST_RUN : ST_WAIT_SYNC;
      phase                 <= adv ? W32 && !ph_n : ph_n;
      encoded_tx_data_valid <= adv;
      encoded_tx_hdr_valid  <= adv && !ph_n;
      tx_gbx_sync           <= tx_gbx_req_sync && state != ST_IDLE;
      enc_tx_ready          <= adv && (!W32 || ph_n);
      enc_tx_half           <= adv ? ph_n : enc_tx_half;
      stat_stall_err        <= stall_c && W32 && phase;
      stat_locked           <= run_n;
    end
  end
endmodule

// File: tb/tb_taxi_eth_phy_10g_tx_gbx_ctrl.sv
// tb_taxi_eth_phy_10g_tx_gbx_ctrl: self-checking bench for the TX gearbox control, three configurations against a block-level model
module tb_taxi_eth_phy_10g_tx_gbx_ctrl;
  typedef struct packed {
    logic dv, hv, sy, rdy, half;
    logic [5:0] cnt;
    logic err, lock;
  } obs_t;
  typedef struct {
    int mode;
    int cnt;
    bit ph;
    obs_t o;
  } mdl_t;
  logic clk = 1'b0;
  logic rst_a = 1'b1, sync_a = 1'b0, stall_a = 1'b0;
  logic rst_b = 1'b1, sync_b = 1'b0, stall_b = 1'b0;
  logic dv_a, hv_a, sy_a, rdy_a, half_a, err_a, lock_a;
  logic dv_b, hv_b, sy_b, rdy_b, half_b, err_b, lock_b;
  logic dv_c, hv_c, sy_c, rdy_c, half_c, err_c, lock_c;
  logic [5:0] cnt_a, cnt_b, cnt_c;
  obs_t oa, ob, oc;
  mdl_t ma, mb, mc;
  int tests = 0, fails = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  taxi_eth_phy_10g_tx_gbx_ctrl #(.DATA_W(64), .INT_SEQ_EN(1'b1), .SEQ_LEN(33), .SYNC_WAIT_EN(1'b1)) u_a (
    .clk(clk), .rst(rst_a), .tx_gbx_req_sync(sync_a), .tx_gbx_req_stall(stall_a),
    .encoded_tx_data_valid(dv_a), .encoded_tx_hdr_valid(hv_a), .tx_gbx_sync(sy_a),
    .enc_tx_ready(rdy_a), .enc_tx_half(half_a), .stat_seq_count(cnt_a),
    .stat_stall_err(err_a), .stat_locked(lock_a)
  );
  taxi_eth_phy_10g_tx_gbx_ctrl #(.DATA_W(32), .INT_SEQ_EN(1'b0), .SEQ_LEN(33), .SYNC_WAIT_EN(1'b1)) u_b (
    .clk(clk), .rst(rst_b), .tx_gbx_req_sync(sync_b), .tx_gbx_req_stall(stall_b),
    .encoded_tx_data_valid(dv_b), .encoded_tx_hdr_valid(hv_b), .tx_gbx_sync(sy_b),
    .enc_tx_ready(rdy_b), .enc_tx_half(half_b), .stat_seq_count(cnt_b),
    .stat_stall_err(err_b), .stat_locked(lock_b)
  );
  taxi_eth_phy_10g_tx_gbx_ctrl #(.DATA_W(32), .INT_SEQ_EN(1'b1), .SEQ_LEN(4), .SYNC_WAIT_EN(1'b1)) u_c (
    .clk(clk), .rst(rst_b), .tx_gbx_req_sync(sync_b), .tx_gbx_req_stall(stall_b),
    .encoded_tx_data_valid(dv_c), .encoded_tx_hdr_valid(hv_c), .tx_gbx_sync(sy_c),
    .enc_tx_ready(rdy_c), .enc_tx_half(half_c), .stat_seq_count(cnt_c),
    .stat_stall_err(err_c), .stat_locked(lock_c)
  );
  assign oa = {dv_a, hv_a, sy_a, rdy_a, half_a, cnt_a, err_a, lock_a};
  assign ob = {dv_b, hv_b, sy_b, rdy_b, half_b, cnt_b, err_b, lock_b};
  assign oc = {dv_c, hv_c, sy_c, rdy_c, half_c, cnt_c, err_c, lock_c};
  function automatic mdl_t step(mdl_t m, int dw, bit int_en, int len, bit r, bit sync, bit stall);
    mdl_t n;
    bit st;
    n = m;
    n.o.dv = 1'b0;
    n.o.hv = 1'b0;
    n.o.sy = 1'b0;
    n.o.rdy = 1'b0;
    n.o.err = 1'b0;
    if (r) begin
      n.mode = 0;
      n.cnt = 0;
      n.ph = 1'b0;
      n.o = '0;
      return n;
    end
    if (m.mode == 0) n.mode = 1;
    else if (m.mode == 2 || sync) begin
      n.mode = 2;
      n.cnt = sync ? 0 : (m.cnt + 1) % len;
      if (sync) n.ph = 1'b0;
      st = !sync && (int_en ? n.cnt == len - 1 : stall);
      if (st) n.o.err = dw == 32 && n.ph;
      else begin
        n.o.dv = 1'b1;
        n.o.hv = !n.ph;
        n.o.half = n.ph;
        n.o.rdy = dw == 64 || n.ph;
        n.o.sy = sync;
        if (dw == 32) n.ph = !n.ph;
      end
    end
    n.o.cnt = 6'(n.cnt);
    n.o.lock = n.mode == 2;
    return n;
  endfunction
  task automatic cmp(string nm, obs_t act, obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got dv/hv/sy/rdy/half/cnt/err/lock=%b expected %b", nm, $time, act, exp);
    end
  endtask
  task automatic pin(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    ma = step(ma, 64, 1'b1, 33, rst_a, sync_a, stall_a);
    mb = step(mb, 32, 1'b0, 33, rst_b, sync_b, stall_b);
    mc = step(mc, 32, 1'b1, 4, rst_b, sync_b, stall_b);
  end
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cfg64_int", oa, ma.o);
      cmp("cfg32_ext", ob, mb.o);
      cmp("cfg32_int", oc, mc.o);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int rdys;
    logic [9:0] hvv, rv;
    ma = '{mode: 0, cnt: 0, ph: 1'b0, o: '0};
    mb = ma;
    mc = ma;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    pin("reset_a", int'(oa), 0);
    pin("reset_b", int'(ob), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    pin("wait_a_unlocked", lock_a, 0);
    sync_a = 1'b1;
    @(negedge clk);
    sync_a = 1'b0;
    pin("a_sync_pulse", sy_a, 1);
    pin("a_first_valid", dv_a, 1);
    pin("a_first_cnt", cnt_a, 0);
    pin("a_locked", lock_a, 1);
    rdys = rdy_a;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      rdys += rdy_a;
      if (i == 1) pin("a_sync_once", sy_a, 0);
      if (i == 31) pin("a_valid_before_stall", dv_a, 1);
    end
    pin("a_stall_slot_dv", dv_a, 0);
    pin("a_stall_slot_cnt", cnt_a, 32);
    pin("a_readies_per_33", rdys, 32);
    @(negedge clk);
    pin("a_after_wrap_dv", dv_a, 1);
    pin("a_after_wrap_cnt", cnt_a, 0);
    rst_a = 1'b1;
    sync_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    sync_a = 1'b0;
    pin("a_rst_beats_sync", int'(oa), 0);
    repeat (62) @(negedge clk);
    pin("b_no_sync_100_locked", lock_b, 0);
    pin("b_no_sync_100_dv", dv_b, 0);
    sync_b = 1'b1;
    @(negedge clk);
    sync_b = 1'b0;
    pin("b_locked_after_sync", lock_b, 1);
    pin("b_sync_pulse", sy_b, 1);
    hvv = '0;
    rv = '0;
    rdys = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      hvv[i] = hv_b;
      rv[i] = rdy_b;
      rdys += rdy_b;
      if (i == 3) pin("c_int_stall_err", err_c, 1);
      if (i == 3) pin("c_int_stall_dv", dv_c, 0);
    end
    pin("b_hdr_pattern", int'(hvv), 'h155);
    pin("b_ready_pattern", int'(rv), 'h2AA);
    pin("b_ready_count", rdys, 5);
    @(negedge clk);
    pin("b_phase0_hdr", hv_b, 1);
    stall_b = 1'b1;
    @(negedge clk);
    stall_b = 1'b0;
    pin("b_midblock_err", err_b, 1);
    pin("b_midblock_dv", dv_b, 0);
    pin("b_midblock_half_hold", half_b, 0);
    @(negedge clk);
    pin("b_err_one_cycle", err_b, 0);
    pin("b_block_completes_half", half_b, 1);
    pin("b_block_completes_rdy", rdy_b, 1);
    @(negedge clk);
    sync_b = 1'b1;
    stall_b = 1'b1;
    @(negedge clk);
    sync_b = 1'b0;
    stall_b = 1'b0;
    pin("b_sync_stall_dv", dv_b, 1);
    pin("b_sync_stall_hv", hv_b, 1);
    pin("b_sync_stall_sy", sy_b, 1);
    pin("b_sync_stall_cnt", cnt_b, 0);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    pin("b_rst_midblock", int'(ob), 0);
    repeat (2) @(negedge clk);
    pin("b_restart_waits", lock_b, 0);
    sync_b = 1'b1;
    @(negedge clk);
    sync_b = 1'b0;
    pin("b_restart_half", half_b, 0);
    pin("b_restart_hdr", hv_b, 1);
    repeat (12) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/taxi_eth_phy_10g_tx_gbx_ctrl.md
TAXI_ETH_PHY_10G_TX_GBX_CTRL -- requirements
Module: taxi_eth_phy_10g_tx_gbx_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 64: SERDES word width; only 32 and 64 are legal.
- INT_SEQ_EN, 1'b0: 1 = internal gearbox sequence counter generates stalls; 0 = stalls come from tx_gbx_req_stall.
- SEQ_LEN, 33: internal sequence length in cycles; the last count is a stall cycle.
- SYNC_WAIT_EN, 1'b1: 1 = remain in WAIT_SYNC until a sync request arrives.
REQ-002 Ports SHALL be:
- clk, input, 1: sole clock.
- rst, input, 1: synchronous, active-high reset.
- tx_gbx_req_sync, input, 1: gearbox resync request.
- tx_gbx_req_stall, input, 1: gearbox stall request.
- encoded_tx_data_valid, output, 1: data word valid, to the TX IF.
- encoded_tx_hdr_valid, output, 1: header valid (block start), to the TX IF.
- tx_gbx_sync, output, 1: sync marker, to the TX IF.
- enc_tx_ready, output, 1: encoder advances one 66-bit block.
- enc_tx_half, output, 1: word half select (DATA_W=32; 0 = first half).
- stat_seq_count, output, 6: current sequence count.
- stat_stall_err, output, 1: one-cycle error pulse.
- stat_locked, output, 1: high in RUN.

Function
REQ-003 All outputs SHALL be registered; each response SHALL appear the cycle after the causing input is sampled.
REQ-004 The FSM SHALL have states IDLE, WAIT_SYNC and RUN.
REQ-005 Transitions:
- IDLE -> WAIT_SYNC on the first cycle after reset when SYNC_WAIT_EN=1, else IDLE -> RUN.
- WAIT_SYNC -> RUN on tx_gbx_req_sync.
- RUN -> RUN on tx_gbx_req_sync, with realignment.
REQ-006 In IDLE and WAIT_SYNC, the valid outputs, enc_tx_ready and tx_gbx_sync SHALL be 0.
REQ-007 In RUN, a non-stall cycle SHALL have encoded_tx_data_valid=1. Stall conditions:
- INT_SEQ_EN=0: stall = tx_gbx_req_stall.
- INT_SEQ_EN=1: stall = (seq count == SEQ_LEN-1).
REQ-008 DATA_W=64 in RUN, non-stall: encoded_tx_hdr_valid=1, enc_tx_ready=1, enc_tx_half=0.
REQ-009 DATA_W=32 in RUN:
- The phase bit SHALL toggle on each non-stall cycle.
- Phase 0 cycles: hdr_valid=1, enc_tx_half=0, enc_tx_ready=0.
- Phase 1 cycles: hdr_valid=0, enc_tx_half=1, enc_tx_ready=1.
REQ-010 On a stall cycle, data_valid, hdr_valid and enc_tx_ready SHALL be 0, and the phase and enc_tx_half SHALL hold their values.
REQ-011 Internal sequence counter:
- Increments every RUN cycle.
- Wraps from SEQ_LEN-1 to 0.
- Resets to 0 on tx_gbx_req_sync.
- stat_seq_count mirrors it.
- When INT_SEQ_EN=0, the counter free-runs and is informational only.
REQ-012 On tx_gbx_req_sync in RUN, the next cycle SHALL have phase=0, hdr_valid=1 and tx_gbx_sync=1 for exactly one cycle; a partially emitted 32-bit block is abandoned.
REQ-013 The WAIT_SYNC -> RUN transition SHALL emit tx_gbx_sync=1 on the first RUN cycle.
REQ-014 If req_sync and req_stall occur in the same cycle, sync SHALL win: counter and phase are reset and the following cycle is valid.
REQ-015 With DATA_W=32, a stall sampled while phase=1 (mid-block) SHALL pulse stat_stall_err for one cycle; the stall is still honored.
REQ-016 stat_locked SHALL be 1 only in RUN.

Reset
REQ-017 When rst=1, the FSM SHALL enter IDLE on the next edge.
REQ-018 Reset values SHALL be: counter=0, phase=0, all outputs 0.
REQ-019 Reset SHALL override a simultaneous sync or stall.
REQ-020 Reset asserted mid-block SHALL discard that block.

Structure
REQ-021 The FSM state enum and the default SEQ_LEN constant SHALL live in package taxi_eth_phy_10g_pkg.
REQ-022 The sequence counter SHALL be sub-module taxi_eth_phy_10g_gbx_seq (inputs: clear, enable; outputs: count, last); no other sub-modules.
REQ-023 Elaboration SHALL fatal on:
- DATA_W not 32 or 64;
- SEQ_LEN < 2;
- SEQ_LEN > 64.

Verification
REQ-024 64-bit, INT_SEQ_EN=1, SEQ_LEN=33, sync at cycle 5: tx_gbx_sync pulses at cycle 6; data_valid is low every 33rd cycle, first at cycle 38; 32 readies per 33 cycles.
REQ-025 32-bit, external stall, sync, then 10 free cycles: hdr_valid pattern 1,0,1,0...; enc_tx_ready on odd cycles only; 5 readies.
REQ-026 32-bit, stall asserted during phase 1: stat_stall_err pulses once; phase holds; block completes on the next non-stall cycle.
REQ-027 Sync and stall in the same cycle during RUN: the next cycle has data_valid=1, hdr_valid=1, tx_gbx_sync=1 and seq_count=0.
REQ-028 SYNC_WAIT_EN=1 with no sync for 100 cycles: all valids stay 0 and stat_locked=0; a sync then gives locked=1 on the next cycle.
REQ-029 rst pulse mid-block in RUN: all outputs are 0 the next cycle; the FSM restarts from IDLE.
